// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/sub, one 4-bit CLA nibble per cycle, LSB first.
// Optional signed-overflow output: define ADDSUB_OVF_EN.
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             oval_q;

  logic st_idle, st_run, st_done;
  logic last;

  logic [3:0] x, y, g, p, s;
  logic [3:0] c;
  logic       c4;

  assign st_idle = (state == IDLE);
  assign st_run  = (state == RUN);
  assign st_done = (state == DONE);
  assign last    = (cnt == CW'(NIB - 1));

  // 4-bit carry-lookahead slice on the current nibble
  always_comb begin
    x    = 4'(opa >> {cnt, 2'b00});
    y    = 4'(opb >> {cnt, 2'b00});
    g    = x & y;
    p    = x ^ y;
    c[0] = carry;
    c[1] = g[0] | (p[0] & carry);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & carry);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry);
    c4   = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    s    = p ^ c;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      st_idle: if (in_valid)  state_n = RUN;
      st_run:  if (last)      state_n = DONE;
      st_done: if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      oval_q <= 1'b0;
    end else begin
      if (st_idle && in_valid) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub | cin;
        cnt   <= '0;
      end
      if (st_run) begin
        sum_q[{cnt, 2'b00} +: 4] <= s;
        carry <= c4;
        cnt   <= cnt + CW'(1);
        if (last) begin
          cout_q <= c4;
          oval_q <= 1'b1;
        end
      end
      if (st_done && out_ready) begin
        oval_q <= 1'b0;
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  // final sum MSB is the top bit of the last slice output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (st_run && last) begin
      ovf_q <= (opa[WIDTH-1] == opb[WIDTH-1])
             & (s[3] != opa[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = st_idle;
  assign busy      = !st_idle;
  assign out_valid = oval_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed and random ops vs arithmetic model.
// Checks ovf as well when ADDSUB_OVF_EN is defined.
module tb_nibble_serial_addsub;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub, cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef ADDSUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic reference
  task automatic model(input logic [W-1:0] ma,
                       input logic [W-1:0] mb,
                       input logic msub,
                       input logic mcin);
    longint ua, ub, r, sa, sb, sr, lim;
    ua  = longint'(ma);
    ub  = longint'(mb);
    lim = longint'(1) << (W - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    if (msub) begin
      r        = ua - ub;
      exp_cout = (ua >= ub);
      sr       = sa - sb;
      if (r < 0) r = r + 2 * lim;
    end else begin
      r        = ua + ub + longint'(mcin);
      exp_cout = (r >= 2 * lim);
      sr       = sa + sb + longint'(mcin);
    end
    exp_sum = W'(r);
    exp_ovf = (sr >= lim) || (sr < -lim);
  endtask

  // Call at a negedge; returns at the negedge after the accept edge
  task automatic start_op(input logic [W-1:0] oa,
                          input logic [W-1:0] ob,
                          input logic os,
                          input logic oc);
    model(oa, ob, os, oc);
    chk("ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = oa; b = ob; sub = os; cin = oc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef ADDSUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  task automatic wait_done(input string tag);
    chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
    for (int k = 1; k <= NIB; k++) begin
      @(negedge clk);
      chk({tag, "_lat"}, 32'(out_valid), 32'(k == NIB));
      chk({tag, "_rdy0"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk_result(tag);
  endtask

  task automatic finish_op(input string tag, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
      chk_result({tag, "_hold"});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    wait_done("add");
    chk("add_const", 32'(sum), 32'h2201);
    finish_op("add", 1);

    start_op(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    wait_done("ripple");
    chk("ripple_const", 32'({cout, sum}), 32'h10000);
    finish_op("ripple", 0);

    start_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_done("sub_pos");
    chk("sub_pos_const", 32'({cout, sum}), 32'h10002);
    finish_op("sub_pos", 0);

    start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done("sub_neg");
    chk("sub_neg_const", 32'({cout, sum}), 32'h0FFFE);
    finish_op("sub_neg", 0);

    // Backpressure with a competing request held on the input
    start_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
    wait_done("bp");
    in_valid = 1'b1;
    a = 16'h0100; b = 16'h0023; sub = 1'b0; cin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk_result("bp_hold");
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ov_clr", 32'(out_valid), 32'd0);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    model(16'h0100, 16'h0023, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("bp_new");
    chk("bp_new_const", 32'(sum), 32'h0124);
    finish_op("bp_new", 0);

    // Reset during RUN
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_sum", 32'(sum), 32'd0);
    chk("mrst_cout", 32'(cout), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done("post_rst");
    chk("post_rst_const", 32'(sum), 32'h0002);
    finish_op("post_rst", 0);

`ifdef ADDSUB_OVF_EN
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done("ovf_add");
    chk("ovf_add_c", 32'({ovf, cout, sum}), 32'h28000);
    finish_op("ovf_add", 0);

    start_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    wait_done("ovf_sub");
    chk("ovf_sub_c", 32'({ovf, cout, sum}), 32'h37FFF);
    finish_op("ovf_sub", 0);

    start_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    wait_done("ovf_none");
    chk("ovf_none_c", 32'(ovf), 32'd0);
    finish_op("ovf_none", 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rs, rc;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ~ra;
      rs = 1'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rs, rc);
      wait_done("rnd");
      finish_op("rnd", int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
